iir_filter_8: RTL and testbench



---
 rtl/iir_filter_8.sv | 77 +++++++
 tb/tb_iir_filter_8.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/iir_filter_8.sv
// Eighth-order direct-form-I IIR low-pass: a 9-tap symmetric FIR on the input history
// plus eight Q1.7 feedback taps on the output history. Data_out is combinational.
module iir_filter_8 #(
  parameter int                 word_size_in  = 8,
  parameter int                 word_size_out = 2*word_size_in+2,
  parameter logic [7:0]         B0 = 8'd7,
  parameter logic [7:0]         B1 = 8'd17,
  parameter logic [7:0]         B2 = 8'd32,
  parameter logic [7:0]         B3 = 8'd46,
  parameter logic [7:0]         B4 = 8'd52,
  parameter logic [7:0]         B5 = 8'd46,
  parameter logic [7:0]         B6 = 8'd32,
  parameter logic [7:0]         B7 = 8'd17,
  parameter logic [7:0]         B8 = 8'd7,
  parameter logic signed [7:0]  A1 = 8'sd64,
  parameter logic signed [7:0]  A2 = 8'sd0,
  parameter logic signed [7:0]  A3 = 8'sd0,
  parameter logic signed [7:0]  A4 = 8'sd0,
  parameter logic signed [7:0]  A5 = 8'sd0,
  parameter logic signed [7:0]  A6 = 8'sd0,
  parameter logic signed [7:0]  A7 = 8'sd0,
  parameter logic signed [7:0]  A8 = 8'sd0
) (
  output logic [word_size_out-1:0] Data_out,
  input  logic [word_size_in-1:0]  Data_in,
  input  logic                     clock,
  input  logic                     reset
);

  localparam int acc_w = 32;

  localparam logic signed [acc_w-1:0] b_coef [0:8] = '{
    signed'(acc_w'(B0)), signed'(acc_w'(B1)), signed'(acc_w'(B2)),
    signed'(acc_w'(B3)), signed'(acc_w'(B4)), signed'(acc_w'(B5)),
    signed'(acc_w'(B6)), signed'(acc_w'(B7)), signed'(acc_w'(B8))
  };

  localparam logic signed [acc_w-1:0] a_coef [1:8] = '{
    acc_w'(A1), acc_w'(A2), acc_w'(A3), acc_w'(A4),
    acc_w'(A5), acc_w'(A6), acc_w'(A7), acc_w'(A8)
  };

  logic [word_size_out-1:0] Samples_in  [1:8];
  logic [word_size_out-1:0] Samples_out [1:8];

  logic signed [acc_w-1:0] ff;
  logic signed [acc_w-1:0] fb;

  always_comb begin
    ff = b_coef[0] * signed'(acc_w'(Data_in));
    fb = '0;
    for (int k = 1; k <= 8; k++) begin
      ff = ff + b_coef[k] * signed'(acc_w'(Samples_in[k]));
      // output history is two's complement, so sign-extend before the multiply
      fb = fb + a_coef[k] * acc_w'(signed'(Samples_out[k]));
    end
  end

  assign Data_out = word_size_out'(ff + (fb >>> 7));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= 8; k++) begin
        Samples_in[k]  <= '0;
        Samples_out[k] <= '0;
      end
    end else begin
      Samples_in[1]  <= word_size_out'(Data_in);
      Samples_out[1] <= Data_out;
      for (int k = 2; k <= 8; k++) begin
        Samples_in[k]  <= Samples_in[k-1];
        Samples_out[k] <= Samples_out[k-1];
      end
    end
  end

endmodule

// File: tb/tb_iir_filter_8.sv
// Directed bench for iir_filter_8: reset, impulse, delay lines, step, async reset,
// and a pure-FIR variant with A1 = 0.
module tb_iir_filter_8;

  logic        clock;
  logic        reset;
  logic [7:0]  Data_in;
  logic [17:0] y;
  logic [17:0] y_fir;

  int checks;
  int errors;

  iir_filter_8 dut (
    .Data_out (y),
    .Data_in  (Data_in),
    .clock    (clock),
    .reset    (reset)
  );

  iir_filter_8 #(.A1(8'sd0)) dut_fir (
    .Data_out (y_fir),
    .Data_in  (Data_in),
    .clock    (clock),
    .reset    (reset)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // post-edge responses once Data_in has returned to 0 after a unit impulse
  int imp_tab [0:15] = '{20, 42, 67, 85, 88, 76, 55, 34, 17, 8, 4, 2, 1, 0, 0, 0};
  int fir_tab [0:15] = '{17, 32, 46, 52, 46, 32, 17, 7, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    logic [17:0] prev;
    int          all_zero;
    int          mono_ok;
    int          sign_ok;
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    Data_in = 8'd0;

    // reset held low
    #2;
    all_zero = 1;
    for (int k = 1; k <= 8; k++)
      if (dut.Samples_in[k] !== 18'd0 || dut.Samples_out[k] !== 18'd0) all_zero = 0;
    check_val("reset_hist_zero", all_zero, 1);
    check_val("reset_out_zero", 32'(y), 0);
    Data_in = 8'd3;
    #1;
    check_val("reset_out_b0x3", 32'(y), 21);
    @(posedge clock); #1;
    check_val("reset_no_shift_in", 32'(dut.Samples_in[1]), 0);
    check_val("reset_no_shift_out", 32'(dut.Samples_out[1]), 0);
    check_val("reset_out_hold", 32'(y), 21);

    // release reset between edges, then a unit impulse
    Data_in = 8'd0;
    reset   = 1'b1;
    @(posedge clock); #1;
    check_val("post_release_zero", 32'(y), 0);
    Data_in = 8'd1;
    @(negedge clock);
    check_val("imp_pre_edge", 32'(y), 7);
    check_val("fir_pre_edge", 32'(y_fir), 7);
    prev = y;
    @(posedge clock); #1;
    Data_in = 8'd0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_val($sformatf("imp_y%0d", i + 1), 32'(y), imp_tab[i]);
      check_val($sformatf("fir_y%0d", i + 1), 32'(y_fir), fir_tab[i]);
      check_val($sformatf("sout1_%0d", i + 1), 32'(dut.Samples_out[1]), 32'(prev));
      for (int k = 1; k <= 8; k++)
        check_val($sformatf("sin%0d_t%0d", k, i + 1), 32'(dut.Samples_in[k]),
                  (k == i + 1) ? 1 : 0);
      prev = y;
      @(posedge clock); #1;
    end

    // step from reset
    reset = 1'b0;
    #1;
    reset   = 1'b1;
    Data_in = 8'd255;
    #1;
    check_val("step_y0", 32'(y), 1785);
    prev = y;
    @(posedge clock); #1;
    check_val("step_y1", 32'(y), 7012);
    mono_ok = 1;
    sign_ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (y < prev) mono_ok = 0;
      if (y[17]) sign_ok = 0;
      prev = y;
      @(posedge clock); #1;
    end

    // async reset between edges, mid step response
    check_val("step_mid_nonzero", (y > 18'd7012) ? 1 : 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_sin1_clear", 32'(dut.Samples_in[1]), 0);
    check_val("async_sout8_clear", 32'(dut.Samples_out[8]), 0);
    check_val("async_out_1785", 32'(y), 1785);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("restart_y1", 32'(y), 7012);
    prev = y;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (y < prev) mono_ok = 0;
      if (y[17]) sign_ok = 0;
      prev = y;
    end
    check_val("step_monotonic", mono_ok, 1);
    check_val("step_no_sign_flip", sign_ok, 1);
    check_val("step_settle", 32'(y), 130559);
    @(posedge clock); #1;
    check_val("step_settle_hold", 32'(y), 130559);
    check_val("fir_step_settle", 32'(y_fir), 65280);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
